// File: rtl/uart_debug_pkg.sv
// Shared debug-UART definitions: rx state encoding, baud divider derivation, data width.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package uart_debug_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Clocks per bit; the pairing requires CLK_FREQ to be an integer multiple of BAUD_RATE.
    function automatic int calc_clk_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Clocks from the detected falling edge to the middle of the start bit.
    function automatic int calc_half(input int clk_freq, input int baud_rate);
        return calc_clk_div(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk from d to q.
// Backpressure: none; samples every cycle.
module uart_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Resolve metastability over two stages; reset to the line's idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_debug_rx.sv
// Debug UART receiver: 8N1 (8E1 when UART_DEBUG_RX_PARITY_EN is defined) serial line to bytes.
// Latency: valid_out/frame_err 1 clk after the mid-stop-bit sample (~9.5 bit times + 3 clk).
// Backpressure: none; each byte is pulsed once on valid_out and must be taken that cycle.
module uart_debug_rx
    import uart_debug_pkg::*;
#(
    parameter int BAUD_RATE = 115200,
    parameter int CLK_FREQ  = 100000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int          CLK_DIV = calc_clk_div(CLK_FREQ, BAUD_RATE);
    localparam int          HALF    = calc_half(CLK_FREQ, BAUD_RATE);
    localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [15:0]          clk_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_DEBUG_RX_PARITY_EN
    logic                 par_bad;
`endif

    // Idle-high reset value keeps a reset release from looking like a start bit.
    uart_sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame FSM: mid-bit sampling, shift register and registered strobes/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_DEBUG_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        busy    <= 1'b1;
                        clk_cnt <= 16'd0;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= 16'd0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
`ifdef UART_DEBUG_RX_PARITY_EN
                            par_bad <= 1'b0;
`endif
                        end else begin
                            // Line back high at mid start bit: treat as noise, no flag.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (clk_cnt == DIV_M1) begin
                        // LSB arrives first, so shifting right leaves it at bit 0.
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        clk_cnt   <= 16'd0;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_DEBUG_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`ifdef UART_DEBUG_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == DIV_M1) begin
                        // Even parity: the parity bit equals the XOR of the data bits.
                        par_bad <= (rx_s != ^shift_reg);
                        clk_cnt <= 16'd0;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == DIV_M1) begin
                        clk_cnt <= 16'd0;
                        state   <= IDLE;
                        busy    <= 1'b0;
`ifdef UART_DEBUG_RX_PARITY_EN
                        if (rx_s && !par_bad) begin
`else
                        if (rx_s) begin
`endif
                            data_out  <= shift_reg;
                            valid_out <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_debug_rx.sv
// Bench for uart_debug_rx: directed cases plus random frames against an event-level model.
// Latency: drives one bit per 16 clk (CLK_FREQ=1600, BAUD_RATE=100).
// Backpressure: not applicable.
module tb_uart_debug_rx;

    localparam int CLK_FREQ  = 1600;
    localparam int BAUD_RATE = 100;
    localparam int CLK_DIV   = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Event word: {valid_out, frame_err, data_out}
    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] last_good;

    always #5 clk = ~clk;

    uart_debug_rx #(
        .BAUD_RATE (BAUD_RATE),
        .CLK_FREQ  (CLK_FREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .valid_out (valid_out),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // Record every cycle where a strobe is high; a stretched pulse shows up as an extra event.
    always @(negedge clk) begin
        if (rst_n && (valid_out || frame_err))
            obs_q.push_back({valid_out, frame_err, data_out});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    // Sends one frame and records what the receiver must report for it.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        logic ok;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_DEBUG_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
        ok = stop && !par_flip;
`else
        ok = stop;
`endif
        drive_bit(stop);
        rx = 1'b1;
        if (ok) begin
            exp_q.push_back({2'b10, b});
            last_good = b;
        end else begin
            exp_q.push_back({2'b01, last_good});
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic compare_events(input string tag);
        int n;
        wait_idle(tag);
        chk({tag, "_nevt"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_evt%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        logic       pf;

        last_good = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(data_out),  32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        chk("rst_busy",  32'(busy),      32'h0);

        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        compare_events("post_rst");

        // 1: single good byte
        send_frame(8'hA5, 1'b1, 1'b0);
        compare_events("t1");
        chk("t1_data", 32'(data_out), 32'hA5);

        // 2: back-to-back frames, one stop bit
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        compare_events("t2");
        chk("t2_data", 32'(data_out), 32'hFF);

        // 3: short glitch on an idle line
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        compare_events("t3");

        // 4: stop bit held low
        send_frame(8'h3C, 1'b0, 1'b0);
        compare_events("t4");
        chk("t4_data", 32'(data_out), 32'hFF);

        // 5: reset in the middle of the data bits of 8'h81
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        chk("t5_rst_data",  32'(data_out),  32'h0);
        chk("t5_rst_valid", 32'(valid_out), 32'h0);
        chk("t5_rst_ferr",  32'(frame_err), 32'h0);
        chk("t5_rst_busy",  32'(busy),      32'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        last_good = 8'h00;
        obs_q.delete();
        exp_q.delete();
        repeat (20) @(negedge clk);
        send_frame(8'h42, 1'b1, 1'b0);
        compare_events("t5");
        chk("t5_data", 32'(data_out), 32'h42);

`ifdef UART_DEBUG_RX_PARITY_EN
        // 6: even parity good, then bad
        send_frame(8'h07, 1'b1, 1'b0);
        compare_events("t6a");
        chk("t6a_data", 32'(data_out), 32'h07);
        send_frame(8'hF0, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        compare_events("t6b");
        chk("t6b_data", 32'(data_out), 32'hF0);
`endif

        // Random frames: arbitrary bytes, occasional bad stop (and bad parity when enabled)
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            pf   = ($urandom_range(0, 3) == 0);
            send_frame(b, stop, pf);
            compare_events($sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d_data", i), 32'(data_out), 32'(last_good));
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
